// File: rtl/pipeline_stage_memory_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The stage is the master: it raises req and holds the access until ack.
interface pipeline_stage_memory_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            byte_en;
    logic [31:0]           wdata;
    logic                  ack;
    logic [31:0]           rdata;

    modport master (
        output req, we, addr, byte_en, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, byte_en, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/pipeline_stage_memory.sv
// Memory stage of the 5-stage pipeline: performs byte/half/word loads and
// stores over a req/ack data-memory bus, forwards its in-flight register write
// to execution, stalls execution while an access is outstanding, and hands a
// finalized result to writeback.
module pipeline_stage_memory #(
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ex_bubbled,
    input  logic                    ex_reg_write_enabled,
    input  logic [REG_ID_WIDTH-1:0] ex_reg_write_id,
    input  logic                    ex_reg_data_write_ready,
    input  logic [31:0]             ex_reg_data_write,
    input  logic                    ex_mem_read,
    input  logic                    ex_mem_write,
    input  logic [1:0]              ex_mem_size,
    input  logic                    ex_mem_unsigned,
    input  logic [ADDR_WIDTH-1:0]   ex_dm_address,
    input  logic [31:0]             ex_store_data,
    output logic                    stall_from_memory,
    pipeline_stage_memory_if.master dm,
    output logic [REG_ID_WIDTH-1:0] fwd_reg_id,
    output logic                    fwd_data_ready,
    output logic [31:0]             fwd_data,
    output logic                    wb_valid,
    output logic [REG_ID_WIDTH-1:0] wb_reg_write_id,
    output logic [31:0]             wb_reg_data,
    output logic                    misaligned
);

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            default: r = (a != 2'b00);
        endcase
        return r;
    endfunction

    // Byte-lane enables for an access of the given size at lane offset a.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] r;
        case (size)
            2'b00:   r = 4'b0001 << a;
            2'b01:   r = 4'b0011 << a;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Store data replicated across lanes so any enabled lane carries the right bytes.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Pull the addressed lanes out of the read word and sign/zero-extend them.
    function automatic logic [31:0] lane_load(input logic [1:0] size, input logic [1:0] a,
                                              input logic uns, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {a, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Stage register M
    logic                    m_valid_q;
    logic                    m_reg_write_enabled_q;
    logic [REG_ID_WIDTH-1:0] m_reg_write_id_q;
    logic                    m_reg_data_write_ready_q;
    logic [31:0]             m_reg_data_write_q;
    logic                    m_mem_read_q;
    logic                    m_mem_write_q;
    logic [1:0]              m_mem_size_q;
    logic                    m_mem_unsigned_q;
    logic [ADDR_WIDTH-1:0]   m_dm_address_q;
    logic [31:0]             m_store_data_q;
    logic                    m_misaligned_q;
    logic                    m_done_q;
    logic [31:0]             m_load_data_q;

    // Writeback register
    logic                    wb_valid_q;
    logic [REG_ID_WIDTH-1:0] wb_reg_write_id_q;
    logic [31:0]             wb_reg_data_q;

    logic                    need_access_s;
    logic                    ack_s;
    logic [31:0]             m_load_data_d;
    logic [REG_ID_WIDTH-1:0] wb_reg_write_id_d;
    logic [31:0]             wb_reg_data_d;

    // An access is outstanding until acked; misaligned ops never touch memory.
    assign need_access_s = m_valid_q & (m_mem_read_q | m_mem_write_q) & ~m_done_q & ~m_misaligned_q;
    assign ack_s         = need_access_s & dm.ack;

    assign stall_from_memory = need_access_s;
    assign dm.req     = need_access_s;
    assign dm.we      = m_mem_write_q;
    assign dm.addr    = {m_dm_address_q[ADDR_WIDTH-1:2], 2'b00};
    assign dm.byte_en = lane_enable(m_mem_size_q, m_dm_address_q[1:0]);
    assign dm.wdata   = lane_wdata(m_mem_size_q, m_store_data_q);

    // A misaligned op never stalls, so it sits in M for exactly one cycle.
    assign misaligned = m_valid_q & (m_mem_read_q | m_mem_write_q) & m_misaligned_q;

    // Next-state values for load capture and the finalized writeback result.
    always_comb begin
        m_load_data_d     = m_load_data_q;
        wb_reg_write_id_d = '0;
        wb_reg_data_d     = m_reg_data_write_q;
        if (m_mem_read_q) begin
            m_load_data_d = lane_load(m_mem_size_q, m_dm_address_q[1:0], m_mem_unsigned_q, dm.rdata);
            wb_reg_data_d = m_load_data_q;
        end else begin
            m_load_data_d = m_load_data_q;
            wb_reg_data_d = m_reg_data_write_q;
        end
        if (m_reg_write_enabled_q) begin
            wb_reg_write_id_d = m_reg_write_id_q;
        end else begin
            wb_reg_write_id_d = '0;
        end
    end

    // Forwarding view of the register write currently held in M.
    always_comb begin
        fwd_reg_id     = '0;
        fwd_data_ready = 1'b1;
        fwd_data       = 32'h0000_0000;
        if (!m_valid_q || !m_reg_write_enabled_q) begin
            fwd_reg_id     = '0;
            fwd_data_ready = 1'b1;
            fwd_data       = 32'h0000_0000;
        end else if (m_mem_read_q) begin
            fwd_reg_id     = m_reg_write_id_q;
            fwd_data_ready = m_done_q | m_misaligned_q;
            fwd_data       = m_load_data_q;
        end else begin
            fwd_reg_id     = m_reg_write_id_q;
            fwd_data_ready = m_reg_data_write_ready_q;
            fwd_data       = m_reg_data_write_q;
        end
    end

    // Stage register M: load from EX when not stalled, else record the ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid_q                <= 1'b0;
            m_reg_write_enabled_q    <= 1'b0;
            m_reg_write_id_q         <= '0;
            m_reg_data_write_ready_q <= 1'b0;
            m_reg_data_write_q       <= 32'h0000_0000;
            m_mem_read_q             <= 1'b0;
            m_mem_write_q            <= 1'b0;
            m_mem_size_q             <= 2'b00;
            m_mem_unsigned_q         <= 1'b0;
            m_dm_address_q           <= '0;
            m_store_data_q           <= 32'h0000_0000;
            m_misaligned_q           <= 1'b0;
            m_done_q                 <= 1'b0;
            m_load_data_q            <= 32'h0000_0000;
        end else if (!need_access_s) begin
            m_valid_q                <= ~ex_bubbled;
            m_reg_write_enabled_q    <= ex_reg_write_enabled;
            m_reg_write_id_q         <= ex_reg_write_id;
            m_reg_data_write_ready_q <= ex_reg_data_write_ready;
            m_reg_data_write_q       <= ex_reg_data_write;
            m_mem_read_q             <= ex_mem_read;
            m_mem_write_q            <= ex_mem_write;
            m_mem_size_q             <= ex_mem_size;
            m_mem_unsigned_q         <= ex_mem_unsigned;
            m_dm_address_q           <= ex_dm_address;
            m_store_data_q           <= ex_store_data;
            m_misaligned_q           <= (ex_mem_read | ex_mem_write) &
                                        is_misaligned(ex_mem_size, ex_dm_address[1:0]);
            m_done_q                 <= 1'b0;
            m_load_data_q            <= 32'h0000_0000;
        end else if (ack_s) begin
            m_done_q      <= 1'b1;
            m_load_data_q <= m_load_data_d;
        end
    end

    // Writeback register: take the finalized M result, or insert a bubble while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q        <= 1'b0;
            wb_reg_write_id_q <= '0;
            wb_reg_data_q     <= 32'h0000_0000;
        end else if (!need_access_s) begin
            wb_valid_q        <= m_valid_q;
            wb_reg_write_id_q <= wb_reg_write_id_d;
            wb_reg_data_q     <= wb_reg_data_d;
        end else begin
            wb_valid_q <= 1'b0;
        end
    end

    // A bubble in writeback shows id 0 and data 0.
    assign wb_valid        = wb_valid_q;
    assign wb_reg_write_id = wb_valid_q ? wb_reg_write_id_q : '0;
    assign wb_reg_data     = wb_valid_q ? wb_reg_data_q : 32'h0000_0000;

endmodule

// File: tb/tb_pipeline_stage_memory.sv
// Randomized bench for the memory stage: a byte-addressed reference memory and
// an instruction-level model predict forwarding, stall, bus and writeback values.
module tb_pipeline_stage_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_bubbled;
    logic        ex_reg_write_enabled;
    logic [4:0]  ex_reg_write_id;
    logic        ex_reg_data_write_ready;
    logic [31:0] ex_reg_data_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic [31:0] ex_dm_address;
    logic [31:0] ex_store_data;
    logic        stall_from_memory;
    logic [4:0]  fwd_reg_id;
    logic        fwd_data_ready;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic [4:0]  wb_reg_write_id;
    logic [31:0] wb_reg_data;
    logic        misaligned;

    pipeline_stage_memory_if #(.ADDR_WIDTH(32)) dm_bus ();

    pipeline_stage_memory #(.ADDR_WIDTH(32), .REG_ID_WIDTH(5)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .ex_bubbled              (ex_bubbled),
        .ex_reg_write_enabled    (ex_reg_write_enabled),
        .ex_reg_write_id         (ex_reg_write_id),
        .ex_reg_data_write_ready (ex_reg_data_write_ready),
        .ex_reg_data_write       (ex_reg_data_write),
        .ex_mem_read             (ex_mem_read),
        .ex_mem_write            (ex_mem_write),
        .ex_mem_size             (ex_mem_size),
        .ex_mem_unsigned         (ex_mem_unsigned),
        .ex_dm_address           (ex_dm_address),
        .ex_store_data           (ex_store_data),
        .stall_from_memory       (stall_from_memory),
        .dm                      (dm_bus),
        .fwd_reg_id              (fwd_reg_id),
        .fwd_data_ready          (fwd_data_ready),
        .fwd_data                (fwd_data),
        .wb_valid                (wb_valid),
        .wb_reg_write_id         (wb_reg_write_id),
        .wb_reg_data             (wb_reg_data),
        .misaligned              (misaligned)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        valid;
        bit        we;
        bit        rdy;
        bit        rd;
        bit        wr;
        bit        uns;
        bit [4:0]  id;
        bit [1:0]  size;
        bit [31:0] data;
        bit [31:0] addr;
        bit [31:0] sd;
    } ins_t;

    int n_checks = 0;
    int n_pass   = 0;

    bit [7:0]  ref_b [256];   // reference memory, bytes at 0x100..0x1FF
    bit [31:0] mem_w [64];    // responder memory, words at 0x100..0x1FF

    ins_t      cur;           // instruction the model places in M
    ins_t      pres;          // instruction presented by execution
    bit        cur_done;
    bit [31:0] cur_ld;
    bit        exp_wb_valid;
    bit [4:0]  exp_wb_id;
    bit [31:0] exp_wb_data;
    bit        acc_on;
    int        lat;
    int        waited;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input bit [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input ins_t i);
        return (i.rd || i.wr) && ((int'(i.addr[1:0]) % nbytes(i.size)) != 0);
    endfunction

    function automatic bit [31:0] ref_load(input ins_t i);
        int     n    = nbytes(i.size);
        int     base = int'(i.addr) - 256;
        longint v    = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(ref_b[base + k]) << (8 * k));
        if (!i.uns && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        bit [31:0] r;
        int kind;
        r        = $urandom;
        kind     = $urandom_range(0, 2);
        i.valid  = ($urandom_range(0, 9) >= 2);
        i.rd     = (kind == 1);
        i.wr     = (kind == 2);
        i.we     = (kind == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
        i.id     = r[4:0];
        i.rdy    = r[5];
        i.size   = r[7:6];
        i.uns    = r[8];
        i.data   = $urandom;
        i.sd     = $urandom;
        i.addr   = 32'h100 + 32'($urandom_range(0, 255));
        if (r[9]) i.addr[1:0] = 2'b00;
        return i;
    endfunction

    task automatic drive_ex(input ins_t i);
        ex_bubbled              = !i.valid;
        ex_reg_write_enabled    = i.we;
        ex_reg_write_id         = i.id;
        ex_reg_data_write_ready = i.rdy;
        ex_reg_data_write       = i.data;
        ex_mem_read             = i.rd;
        ex_mem_write            = i.wr;
        ex_mem_size             = i.size;
        ex_mem_unsigned         = i.uns;
        ex_dm_address           = i.addr;
        ex_store_data           = i.sd;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_dm_req"},   32'(dm_bus.req), 32'd0);
        check_eq({tag, "_stall"},    32'(stall_from_memory), 32'd0);
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check_eq({tag, "_wb_id"},    32'(wb_reg_write_id), 32'd0);
        check_eq({tag, "_wb_data"},  wb_reg_data, 32'd0);
        check_eq({tag, "_fwd_id"},   32'(fwd_reg_id), 32'd0);
        check_eq({tag, "_fwd_rdy"},  32'(fwd_data_ready), 32'd1);
        check_eq({tag, "_fwd_data"}, fwd_data, 32'd0);
        check_eq({tag, "_misalign"}, 32'(misaligned), 32'd0);
    endtask

    // One clock: called at a negedge, checks outputs, drives inputs, advances the model.
    task automatic cycle();
        bit        exp_stall;
        bit        ack_now;
        bit [3:0]  en;
        bit [31:0] wd;
        int        a;
        int        n;
        int        idx;
        bit [4:0]  fid;
        bit        frdy;
        bit [31:0] fdata;
        bit        s_we;
        bit [3:0]  s_en;
        bit [31:0] s_wd;

        exp_stall = cur.valid && (cur.rd || cur.wr) && !is_mis(cur) && !cur_done;
        check_eq("stall", 32'(stall_from_memory), 32'(exp_stall));
        check_eq("dm_req", 32'(dm_bus.req), 32'(exp_stall));
        check_eq("misaligned", 32'(misaligned), 32'(cur.valid && is_mis(cur)));

        if (!cur.valid || !cur.we) begin
            fid = 5'd0; frdy = 1'b1; fdata = 32'd0;
        end else if (cur.rd) begin
            fid = cur.id; frdy = cur_done || is_mis(cur); fdata = cur_ld;
        end else begin
            fid = cur.id; frdy = cur.rdy; fdata = cur.data;
        end
        check_eq("fwd_id", 32'(fwd_reg_id), 32'(fid));
        check_eq("fwd_rdy", 32'(fwd_data_ready), 32'(frdy));
        if (frdy) check_eq("fwd_data", fwd_data, fdata);

        check_eq("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
        check_eq("wb_id", 32'(wb_reg_write_id), 32'(exp_wb_id));
        check_eq("wb_data", wb_reg_data, exp_wb_data);

        ack_now = 1'b0;
        if (exp_stall) begin
            if (!acc_on) begin
                acc_on = 1'b1;
                lat    = $urandom_range(0, 3);
                waited = 0;
                a  = int'(cur.addr[1:0]);
                n  = nbytes(cur.size);
                en = 4'b0000;
                for (int k = 0; k < n; k++) en[a + k] = 1'b1;
                for (int j = 0; j < 4; j++) wd[8 * j +: 8] = cur.sd[8 * (j % n) +: 8];
                check_eq("dm_we", 32'(dm_bus.we), 32'(cur.wr));
                check_eq("dm_addr", dm_bus.addr, {cur.addr[31:2], 2'b00});
                check_eq("dm_byte_en", 32'(dm_bus.byte_en), 32'(en));
                if (cur.wr) check_eq("dm_wdata", dm_bus.wdata, wd);
            end
            ack_now = (waited == lat);
            waited++;
        end else begin
            ack_now = ($urandom_range(0, 9) == 0);
        end

        idx  = (int'(dm_bus.addr) - 256) >>> 2;
        s_we = dm_bus.we;
        s_en = dm_bus.byte_en;
        s_wd = dm_bus.wdata;
        dm_bus.ack   = ack_now;
        dm_bus.rdata = (exp_stall && ack_now && idx >= 0 && idx < 64) ? mem_w[idx] : $urandom;
        drive_ex(pres);

        @(posedge clock);
        if (exp_stall) begin
            if (ack_now) begin
                cur_done = 1'b1;
                acc_on   = 1'b0;
                if (s_we && idx >= 0 && idx < 64) begin
                    for (int j = 0; j < 4; j++)
                        if (s_en[j]) mem_w[idx][8 * j +: 8] = s_wd[8 * j +: 8];
                end
            end
            exp_wb_valid = 1'b0;
            exp_wb_id    = 5'd0;
            exp_wb_data  = 32'd0;
        end else begin
            exp_wb_valid = cur.valid;
            exp_wb_id    = (cur.valid && cur.we) ? cur.id : 5'd0;
            exp_wb_data  = cur.valid ? (cur.rd ? cur_ld : cur.data) : 32'd0;
            cur      = pres;
            cur_done = 1'b0;
            cur_ld   = (pres.valid && pres.rd && !is_mis(pres)) ? ref_load(pres) : 32'd0;
            if (pres.valid && pres.wr && !is_mis(pres)) begin
                for (int k = 0; k < nbytes(pres.size); k++)
                    ref_b[int'(pres.addr) - 256 + k] = pres.sd[8 * k +: 8];
            end
            pres = rand_ins();
        end
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ins_t target;
        bit   found;

        for (int w = 0; w < 64; w++) begin
            mem_w[w] = $urandom;
            for (int k = 0; k < 4; k++) ref_b[4 * w + k] = mem_w[w][8 * k +: 8];
        end
        cur          = '{default: 0};
        cur_done     = 1'b0;
        cur_ld       = 32'd0;
        exp_wb_valid = 1'b0;
        exp_wb_id    = 5'd0;
        exp_wb_data  = 32'd0;
        acc_on       = 1'b0;
        pres         = rand_ins();
        reset        = 1'b1;
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        drive_ex('{default: 0});

        repeat (2) @(negedge clock);
        check_idle("reset");
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) cycle();

        // Reset in the middle of an outstanding aligned word load, then a stray ack.
        target       = '{default: 0};
        target.valid = 1'b1;
        target.rd    = 1'b1;
        target.we    = 1'b1;
        target.id    = 5'd9;
        target.size  = 2'b10;
        target.addr  = 32'h104;
        pres         = target;
        found        = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            cycle();
            found = cur.valid && cur.rd && cur.addr == 32'h104 && cur.id == 5'd9 && !cur_done;
            if (!found && pres.id != 5'd9) pres = target;
        end
        check_eq("reach_target", 32'(found), 32'd1);
        check_eq("target_req", 32'(dm_bus.req), 32'd1);
        check_eq("target_fwd_id", 32'(fwd_reg_id), 32'd9);
        check_eq("target_fwd_rdy", 32'(fwd_data_ready), 32'd0);

        reset = 1'b1;
        #1;
        check_idle("midreset");
        ex_bubbled = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset        = 1'b0;
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = $urandom;
        @(posedge clock);
        @(negedge clock);
        dm_bus.ack = 1'b0;
        check_idle("strayack");
        @(posedge clock);
        @(negedge clock);
        check_idle("afterstray");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
